// File: rtl/shift_reg_pkg.sv
// Shared types for the shift_reg loader: FSM state encoding, direction
// constants and a small constant-expression helper.
package shift_reg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2,
    GAP   = 2'd3
  } loader_state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/shift_reg_loader_cnt.sv
// Clearable up-counter with terminal-count flag; it saturates at the
// terminal value instead of wrapping. Shared by the SHIFT and GAP phases.
module shift_reg_loader_cnt #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          inc,
  input  logic [CW-1:0] term,
  output logic          at_term
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign at_term = (cnt_q == term);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !at_term) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/shift_reg_loader.sv
// Serializes one parallel word into shift_reg's d/en/dir inputs over MSB
// enabled clocks. Optional parity output enabled by SHIFT_REG_LOADER_PARITY_EN.
module shift_reg_loader
  import shift_reg_pkg::*;
#(
  parameter int MSB = 4,
  parameter int GAP = 1
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [MSB-1:0] in_data,
  input  logic           in_dir,
  input  logic           in_valid,
  output logic           in_ready,
  output logic           d,
  output logic           en,
  output logic           dir,
  output logic           busy,
  output logic           done
`ifdef SHIFT_REG_LOADER_PARITY_EN
  ,
  output logic           par
`endif
);

  // Handshake: a word is taken on a rising edge where in_valid && in_ready;
  // in_valid is ignored whenever in_ready is low.

  localparam int CW = $clog2(max_int(MSB, GAP) + 1);
  localparam logic [CW-1:0] SHIFT_TERM = CW'(MSB - 1);
  localparam logic [CW-1:0] GAP_TERM   = CW'((GAP > 0) ? GAP - 1 : 0);

  loader_state_t  state_q, state_d;
  logic [MSB-1:0] word_q, word_d;
  logic           dir_q, dir_d;
  logic           d_q, d_d;
  logic           en_q, en_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           in_ready_q, in_ready_d;
  logic           cnt_clr, cnt_inc, cnt_at_term;
  logic [CW-1:0]  cnt_term;

  shift_reg_loader_cnt #(.CW(CW)) u_cnt (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .term    (cnt_term),
    .at_term (cnt_at_term)
  );

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    dir_d    = dir_q;
    d_d      = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    cnt_term = (state_q == shift_reg_pkg::GAP) ? GAP_TERM : SHIFT_TERM;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d = SHIFT;
          cnt_clr = 1'b1;
          dir_d   = in_dir;
          // word_q holds the bits not yet sent, leading bit at the outgoing end
          if (in_dir == DIR_RIGHT) begin
            d_d    = in_data[0];
            word_d = in_data >> 1;
          end else begin
            d_d    = in_data[MSB-1];
            word_d = in_data << 1;
          end
        end
      end
      SHIFT: begin
        if (cnt_at_term) begin
          state_d = DONE;
          cnt_clr = 1'b1;
        end else begin
          cnt_inc = 1'b1;
          if (dir_q == DIR_RIGHT) begin
            d_d    = word_q[0];
            word_d = word_q >> 1;
          end else begin
            d_d    = word_q[MSB-1];
            word_d = word_q << 1;
          end
        end
      end
      DONE: begin
        cnt_clr = 1'b1;
        state_d = (GAP > 0) ? shift_reg_pkg::GAP : IDLE;
      end
      shift_reg_pkg::GAP: begin
        if (cnt_at_term) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state so they align with state_q.
    en_d       = (state_d == SHIFT);
    done_d     = (state_d == DONE);
    busy_d     = (state_d != IDLE);
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      word_q     <= '0;
      dir_q      <= 1'b0;
      d_q        <= 1'b0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      dir_q      <= dir_d;
      d_q        <= d_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready = in_ready_q;
  assign d        = d_q;
  assign en       = en_q;
  assign dir      = dir_q;
  assign busy     = busy_q;
  assign done     = done_q;

`ifdef SHIFT_REG_LOADER_PARITY_EN
  logic par_bit_q, par_bit_d;
  logic par_q, par_d;

  always_comb begin
    par_bit_d = par_bit_q;
    if (state_q == IDLE && in_valid && in_ready_q) begin
      par_bit_d = ^in_data;
    end
    par_d = (state_d == DONE) ? par_bit_q : 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      par_bit_q <= 1'b0;
      par_q     <= 1'b0;
    end else begin
      par_bit_q <= par_bit_d;
      par_q     <= par_d;
    end
  end

  assign par = par_q;
`endif

endmodule

// File: tb/tb_shift_reg_loader.sv
// Bench for shift_reg_loader: table vectors, hand-written corner sequences and
// randomized traffic against a cycle-offset reference model.
module tb_shift_reg_loader;

  localparam int MSB = 4;
  localparam int GAP = 1;

  // clock / reset
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [MSB-1:0] in_data = '0;
  logic           in_dir = 1'b0, in_valid = 1'b0;
  logic           in_ready, d, en, dir, busy, done;
  logic [MSB-1:0] in_data0 = '0;
  logic           in_dir0 = 1'b0, in_valid0 = 1'b0;
  logic           in_ready0, d0, en0, dir0, busy0, done0;
`ifdef SHIFT_REG_LOADER_PARITY_EN
  logic par, par0;
`endif

  shift_reg_loader #(.MSB(MSB), .GAP(GAP)) dut (
    .clk(clk), .rstn(rstn), .in_data(in_data), .in_dir(in_dir),
    .in_valid(in_valid), .in_ready(in_ready), .d(d), .en(en), .dir(dir),
    .busy(busy), .done(done)
`ifdef SHIFT_REG_LOADER_PARITY_EN
    , .par(par)
`endif
  );

  shift_reg_loader #(.MSB(MSB), .GAP(0)) dut0 (
    .clk(clk), .rstn(rstn), .in_data(in_data0), .in_dir(in_dir0),
    .in_valid(in_valid0), .in_ready(in_ready0), .d(d0), .en(en0), .dir(dir0),
    .busy(busy0), .done(done0)
`ifdef SHIFT_REG_LOADER_PARITY_EN
    , .par(par0)
`endif
  );

  // downstream shift_reg models: left shifts d into bit 0, right into bit MSB-1
  logic [MSB-1:0] sr_out = '0, sr_out0 = '0;
  always @(posedge clk) begin
    if (en)  sr_out  <= dir  ? {d,  sr_out[MSB-1:1]}  : {sr_out[MSB-2:0], d};
    if (en0) sr_out0 <= dir0 ? {d0, sr_out0[MSB-1:1]} : {sr_out0[MSB-2:0], d0};
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // reference model: ph = edges since the accept edge, -1 when idle
  int             ph = -1;
  logic           rdy_exp = 1'b0, dir_exp = 1'b0;
  logic [MSB-1:0] w_exp = '0;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ph = -1; rdy_exp = 1'b0; dir_exp = 1'b0;
    end else if (ph < 0) begin
      if (in_valid && rdy_exp) begin
        ph = 0; w_exp = in_data; dir_exp = in_dir; rdy_exp = 1'b0;
      end else begin
        rdy_exp = 1'b1;
      end
    end else begin
      ph++;
      if (ph > MSB + GAP) begin
        ph = -1; rdy_exp = 1'b1;
      end
    end
  end

  // scoreboard: every cycle compare dut against the model
  always @(negedge clk) begin
    logic en_e, d_e, done_e;
    en_e   = (ph >= 0) && (ph < MSB);
    d_e    = en_e ? w_exp[dir_exp ? ph : MSB - 1 - ph] : 1'b0;
    done_e = (ph == MSB);
    check("mdl_en", en, en_e);
    check("mdl_d", d, d_e);
    check("mdl_done", done, done_e);
    check("mdl_busy", busy, ph >= 0);
    check("mdl_ready", in_ready, rdy_exp);
    check("mdl_dir", dir, dir_exp);
    if (done_e) check("mdl_out", sr_out, w_exp);
`ifdef SHIFT_REG_LOADER_PARITY_EN
    check("mdl_par", par, done_e ? ^w_exp : 1'b0);
`endif
  end

  // sel: 0 in_ready, 1 done, 2 in_ready0, 3 busy0, 4 done0
  task automatic wait_on(input int sel, input string name);
    logic hit;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      case (sel)
        0: hit = in_ready;
        1: hit = done;
        2: hit = in_ready0;
        3: hit = busy0;
        default: hit = done0;
      endcase
      if (hit) return;
    end
    check(name, 0, 1);
  endtask

  task automatic send_word(input logic [MSB-1:0] data, input logic dr);
    wait_on(0, "ready_timeout");
    in_valid = 1'b1; in_data = data; in_dir = dr;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = MSB'($urandom); in_dir = 1'($urandom);
  endtask

  typedef struct {
    logic [MSB-1:0] data;
    logic           dr;
    logic [MSB-1:0] seq;  // serial bits, seq[MSB-1] sent first
    logic           p;
  } vec_t;

  vec_t vecs[7];
  int   t1, t2;

  initial begin
    vecs[0] = '{4'b1011, 1'b0, 4'b1011, 1'b1};
    vecs[1] = '{4'b1011, 1'b1, 4'b1101, 1'b1};
    vecs[2] = '{4'b1001, 1'b0, 4'b1001, 1'b0};
    vecs[3] = '{4'b0001, 1'b1, 4'b1000, 1'b1};
    vecs[4] = '{4'b1100, 1'b1, 4'b0011, 1'b0};
    vecs[5] = '{4'b0110, 1'b1, 4'b0110, 1'b0};
    vecs[6] = '{4'b1110, 1'b0, 4'b1110, 1'b1};

    // reset values, then in_ready at the first edge after release
    #1;
    check("rst_ready", in_ready, 0);
    check("rst_en", en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_d", d, 0);
    check("rst_dir", dir, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    check("rel_ready", in_ready, 1);

    foreach (vecs[i]) begin
      send_word(vecs[i].data, vecs[i].dr);
      for (int k = 0; k < MSB; k++) begin
        @(negedge clk);
        check("tbl_en", en, 1);
        check("tbl_d", d, vecs[i].seq[MSB-1-k]);
        check("tbl_dir", dir, vecs[i].dr);
      end
      @(negedge clk);
      check("tbl_done", done, 1);
      check("tbl_out", sr_out, vecs[i].data);
      check("tbl_done_dir", dir, vecs[i].dr);
`ifdef SHIFT_REG_LOADER_PARITY_EN
      check("tbl_par", par, vecs[i].p);
`endif
    end

    // in_valid during SHIFT is ignored
    send_word(4'h3, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; in_data = 4'hF;
    @(negedge clk);
    check("busy_ready", in_ready, 0);
    in_valid = 1'b0;
    wait_on(1, "busy_done_timeout");
    check("busy_out", sr_out, 4'h3);

    // back-to-back at GAP=0 on the second instance
    in_valid0 = 1'b1; in_data0 = 4'hA; in_dir0 = 1'b0;
    wait_on(3, "b2b_accept_timeout");
    in_data0 = 4'h5;
    wait_on(4, "b2b_done1_timeout");
    t1 = cyc;
    check("b2b_out1", sr_out0, 4'hA);
    wait_on(2, "b2b_ready_timeout");
    wait_on(3, "b2b_accept2_timeout");
    in_valid0 = 1'b0;
    wait_on(4, "b2b_done2_timeout");
    t2 = cyc;
    check("b2b_spacing", t2 - t1, 6);
    check("b2b_out2", sr_out0, 4'h5);

    // asynchronous reset in the third enabled cycle
    send_word(4'h9, 1'b1);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    check("arst_en", en, 0);
    check("arst_busy", busy, 0);
    check("arst_ready", in_ready, 0);
    check("arst_done", done, 0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("arst_rel_ready", in_ready, 0);
    @(posedge clk); #1;
    check("arst_ready_edge", in_ready, 1);

    // randomized traffic; the per-cycle model comparison does the checking
    repeat (400) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = MSB'($urandom);
      in_dir   = 1'($urandom);
    end
    in_valid = 1'b0;
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
